// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: NOP encoding, fetch FSM states, default reset PC.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: PC+4, redirect target or hold, with misalignment detect.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        hold_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  always_comb begin
    pc_plus4_o   = pc_i + 32'd4;
    misaligned_o = redirect_i && (redirect_target_i[1:0] != 2'b00);
    next_pc_o    = pc_plus4_o;
    // A misaligned redirect leaves the PC where it is; the FSM enters FAULT.
    if (redirect_i && !misaligned_o) begin
      next_pc_o = redirect_target_i;
    end else if (hold_i || misaligned_o) begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and sticky
// misaligned-redirect fault, sequenced by a BOOT/RUN/FAULT state machine.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  // Misaligned RESET_PC values are forced to the containing word.
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_addr_q, fault_addr_d;

  logic         run;
  logic         sel_hold;
  logic         sel_redirect;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;

  assign run          = (state_q == RUN);
  assign sel_hold     = stall_i || !run;
  assign sel_redirect = redirect_i && run;

  next_pc_sel u_next_pc_sel (
    .pc_i              (pc_q),
    .hold_i            (sel_hold),
    .redirect_i        (sel_redirect),
    .redirect_target_i (redirect_target_i),
    .pc_plus4_o        (pc_plus4),
    .next_pc_o         (next_pc),
    .misaligned_o      (misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = next_pc;
    valid_d      = valid_q;
    instr_d      = instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      RUN: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (misaligned) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = redirect_target_i;
          end
        end else if (!stall_i) begin
          valid_d  = 1'b1;
          instr_d  = imem_instr_i;
          id_pc_d  = pc_q;
          id_pc4_d = pc_plus4;
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      default: begin
        state_d = BOOT;
        pc_d    = PC_RST;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= PC_RST;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign if_id_valid_o    = valid_q;
  assign if_id_instr_o    = instr_q;
  assign if_id_pc_o       = id_pc_q;
  assign if_id_pc_plus4_o = id_pc4_q;
  assign fault_o          = fault_q;
  assign fault_addr_o     = fault_addr_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 stall_i  in  1  hold PC and IF/ID register (hazard from decode).
REQ-005 redirect_i  in  1  taken branch/jump from execute; replace PC.
REQ-006 redirect_target_i  in  32  new PC when redirect_i=1.
REQ-007 imem_addr_o  out  32  byte address to instruction memory (= current PC, combinational).
REQ-008 imem_instr_i  in  32  instruction word returned combinationally by instruction memory for imem_addr_o.
REQ-009 if_id_valid_o  out  1  IF/ID register holds a real instruction.
REQ-010 if_id_instr_o  out  32  registered instruction; NOP 32'h0000_0013 when invalid.
REQ-011 if_id_pc_o  out  32  registered PC of if_id_instr_o.
REQ-012 if_id_pc_plus4_o  out  32  registered if_id_pc_o + 4 (mod 2^32).
REQ-013 fault_o  out  1  sticky misaligned-redirect fault.
REQ-014 fault_addr_o  out  32  offending redirect target, valid while fault_o=1.

Function
REQ-015 States: BOOT, RUN, FAULT; BOOT->RUN unconditionally after one cycle; RUN->FAULT on misaligned redirect; FAULT exits only via reset.
REQ-016 BOOT: PC held at RESET_PC, IF/ID stays invalid, stall_i/redirect_i ignored.
REQ-017 RUN, no redirect, stall_i=0: IF/ID <= {valid=1, imem_instr_i, PC, PC+4}; PC <= PC+4; one-cycle fetch latency.
REQ-018 RUN, no redirect, stall_i=1: PC and all IF/ID outputs hold their values.
REQ-019 RUN, redirect_i=1, redirect_target_i[1:0]=00: PC <= target; IF/ID <= valid=0, instr NOP, pc/pc_plus4 unchanged; redirect overrides simultaneous stall_i.
REQ-020 RUN, redirect_i=1, redirect_target_i[1:0]!=00: state <= FAULT; fault_o <= 1; fault_addr_o <= target; PC held; IF/ID <= invalid/NOP.
REQ-021 FAULT: PC held, IF/ID invalid/NOP, fault_o and fault_addr_o held, all inputs except rst_n ignored.
REQ-022 PC increment wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000); no flag raised.
REQ-023 imem_addr_o always word-aligned; bits [1:0] of PC are never non-zero.
REQ-024 if_id_pc_plus4_o computed from the same 32-bit adder as PC+4, no extra cycle.

Reset
REQ-025 rst_n=0 at rising edge: state<=BOOT, PC<=RESET_PC, if_id_valid_o<=0, if_id_instr_o<=32'h0000_0013, if_id_pc_o<=0, if_id_pc_plus4_o<=0, fault_o<=0, fault_addr_o<=0.
REQ-026 Reset takes priority over stall_i, redirect_i and FAULT state; reset mid-operation discards in-flight IF/ID contents.
REQ-027 RESET_PC with bits [1:0]!=00 is a configuration error; low bits forced to 00.

Structure
REQ-028 Shared package cpu_pkg holds NOP_INSTR (32'h0000_0013), fetch_state_t enum (BOOT, RUN, FAULT) and default RESET_PC constant.
REQ-029 One sub-module next_pc_sel: combinational PC+4 / redirect target / hold mux plus misalignment detect; registers stay in fetch_unit.

Verification
REQ-030 Reset with RESET_PC=0, stall/redirect low, memory words 0x00500093,0x00A00113 -> cycle 1 valid=0; cycle 2 valid=1 instr=0x00500093 pc=0; cycle 3 instr=0x00A00113 pc=4 pc_plus4=8.
REQ-031 In RUN at PC=0x10, stall_i=1 for 3 cycles -> imem_addr_o stays 0x10, IF/ID outputs unchanged; fetch resumes at 0x10 then 0x14.
REQ-032 redirect_i=1 target=0x40 together with stall_i=1 -> next cycle valid=0 instr=0x13, imem_addr_o=0x40; following cycle pc=0x40 valid=1.
REQ-033 redirect_i=1 target=0x42 -> fault_o=1, fault_addr_o=0x42, valid=0 thereafter; later redirect to 0x80 ignored; rst_n=0 clears fault_o, PC=RESET_PC.
REQ-034 PC=0xFFFF_FFFC, no stall -> IF/ID pc=0xFFFF_FFFC, pc_plus4=0x0, next imem_addr_o=0x0, fault_o stays 0.
REQ-035 rst_n=0 asserted while valid=1 and PC=0x20 -> next edge valid=0, instr=0x13, PC=RESET_PC, state BOOT.
